// File: rtl/param_uart.sv
`default_nettype none
// ============================================================================
//  Module   : param_uart
//  Purpose  : Parametrised full-duplex UART. It has a 2-flop RX synchroniser,
//             an RX frame decoder feeding a first-word-fall-through FIFO with
//             overrun and framing-error flags, and a valid/ready TX shifter
//             with a power-on guard interval.
//  Options  : Define UART_PARITY_EN to insert one parity bit after the data
//             bits in both directions. PARITY_ODD selects odd (1) or even (0).
//  Revision : 1.0  initial release
// ============================================================================
module param_uart #(
    parameter int CLOCK_FREQUENCY = 16000000,
    parameter int BAUD_RATE       = 115200,
    parameter int DATA_BITS       = 8,
    parameter int STOP_BITS       = 1,
    parameter int RX_FIFO_DEPTH   = 4,
    parameter int PARITY_ODD      = 0
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             ser_rx,
    output logic                             ser_tx,
    output logic                             rx_valid,
    input  logic                             rx_ready,
    output logic [DATA_BITS-1:0]             rx_data,
    output logic [$clog2(RX_FIFO_DEPTH):0]   rx_level,
    output logic                             rx_frame_err,
    output logic                             rx_overrun,
    output logic                             rx_parity_err,
    input  logic                             tx_valid,
    input  logic [DATA_BITS-1:0]             tx_data,
    output logic                             tx_ready
);

    localparam int C_DIV        = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int C_CW         = $clog2(C_DIV + 1);
`ifdef UART_PARITY_EN
    localparam int C_PB         = 1;
    localparam logic C_ODD      = (PARITY_ODD != 0);
`else
    localparam int C_PB         = 0;
`endif
    localparam int C_TX_BITS    = 1 + DATA_BITS + C_PB + STOP_BITS;
    localparam int C_GUARD_BITS = DATA_BITS + 1 + STOP_BITS;
    localparam int C_BW         = $clog2(C_TX_BITS + 1);
    localparam int C_AW         = $clog2(RX_FIFO_DEPTH);
    localparam int C_LW         = C_AW + 1;

    localparam logic [C_CW-1:0] C_DIV_LAST   = C_CW'(C_DIV - 1);
    localparam logic [C_CW-1:0] C_DIV_HALF   = C_CW'(C_DIV / 2);
    localparam logic [C_BW-1:0] C_DATA_LAST  = C_BW'(DATA_BITS - 1);
    localparam logic [C_BW-1:0] C_TX_LAST    = C_BW'(C_TX_BITS - 1);
    localparam logic [C_BW-1:0] C_GUARD_LAST = C_BW'(C_GUARD_BITS - 1);
    localparam logic [C_LW-1:0] C_FULL_LEVEL = C_LW'(RX_FIFO_DEPTH);

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        RX_PARITY = 3'd3,
`endif
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_GUARD = 2'd0,
        TX_IDLE  = 2'd1,
        TX_SHIFT = 2'd2
    } tx_state_t;

    // ------------------------------------------------------------------ RX --
    logic [1:0]           rx_sync_q;
    logic                 rx_s;
    rx_state_t            rx_state_q;
    logic [C_CW-1:0]      rx_cnt_q;
    logic [C_BW-1:0]      rx_bit_q;
    logic [DATA_BITS-1:0] rx_shift_q;
    logic                 rx_frame_err_q;
    logic                 rx_overrun_q;
    logic                 rx_push;
    logic                 rx_pop;
    logic                 rx_push_ok;
    logic                 rx_fifo_full;

    logic [DATA_BITS-1:0] fifo_mem_q [RX_FIFO_DEPTH];
    logic [C_AW-1:0]      wr_ptr_q;
    logic [C_AW-1:0]      rd_ptr_q;
    logic [C_LW-1:0]      rx_level_q;

`ifdef UART_PARITY_EN
    logic                 rx_perr_q;
    logic                 rx_parity_err_q;
`else
    logic                 unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
`endif

    // Bring the asynchronous line into the clock domain; idles high.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rx_sync_q <= 2'b11;
        else         rx_sync_q <= {rx_sync_q[0], ser_rx};
    end

    assign rx_s = rx_sync_q[1];

    // A good stop bit completes the frame in this cycle.
    assign rx_push      = (rx_state_q == RX_STOP) && (rx_cnt_q == C_DIV_LAST) && rx_s;
    assign rx_fifo_full = (rx_level_q == C_FULL_LEVEL);
    assign rx_pop       = rx_valid && rx_ready;
    assign rx_push_ok   = rx_push && (!rx_fifo_full || rx_pop);

    // Frame decoder: mid-bit sampling timed from the start-bit edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_state_q     <= RX_IDLE;
            rx_cnt_q       <= '0;
            rx_bit_q       <= '0;
            rx_shift_q     <= '0;
            rx_frame_err_q <= 1'b0;
            rx_overrun_q   <= 1'b0;
`ifdef UART_PARITY_EN
            rx_perr_q       <= 1'b0;
            rx_parity_err_q <= 1'b0;
`endif
        end else begin
            rx_frame_err_q <= 1'b0;
            rx_overrun_q   <= 1'b0;
`ifdef UART_PARITY_EN
            rx_parity_err_q <= 1'b0;
`endif
            case (rx_state_q)
                RX_IDLE: begin
                    rx_cnt_q <= '0;
                    if (!rx_s) rx_state_q <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt_q == C_DIV_HALF) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        // A start bit that is already gone was a glitch.
                        rx_state_q <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + C_CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == C_DIV_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_s, rx_shift_q[DATA_BITS-1:1]};
                        if (rx_bit_q == C_DATA_LAST) begin
`ifdef UART_PARITY_EN
                            rx_state_q <= RX_PARITY;
`else
                            rx_state_q <= RX_STOP;
`endif
                        end else begin
                            rx_bit_q <= rx_bit_q + C_BW'(1);
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + C_CW'(1);
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (rx_cnt_q == C_DIV_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_perr_q  <= ((^rx_shift_q) ^ rx_s) != C_ODD;
                        rx_state_q <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + C_CW'(1);
                    end
                end
`endif
                RX_STOP: begin
                    if (rx_cnt_q == C_DIV_LAST) begin
                        rx_cnt_q <= '0;
                        if (rx_s) begin
                            rx_overrun_q <= rx_fifo_full && !rx_pop;
`ifdef UART_PARITY_EN
                            rx_parity_err_q <= rx_perr_q;
`endif
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_frame_err_q <= 1'b1;
                            rx_state_q     <= RX_BREAK;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + C_CW'(1);
                    end
                end
                RX_BREAK: begin
                    rx_cnt_q <= '0;
                    if (rx_s) rx_state_q <= RX_IDLE;
                end
                default: begin
                    rx_cnt_q   <= '0;
                    rx_state_q <= RX_IDLE;
                end
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the level says empty.
    always_ff @(posedge clk) begin
        if (rx_push_ok) fifo_mem_q[wr_ptr_q] <= rx_shift_q;
    end

    // FIFO pointers and occupancy; a push into a full FIFO only lands with a pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rx_level_q <= '0;
        end else begin
            if (rx_push_ok) wr_ptr_q <= wr_ptr_q + C_AW'(1);
            if (rx_pop)     rd_ptr_q <= rd_ptr_q + C_AW'(1);
            if (rx_push_ok && !rx_pop)      rx_level_q <= rx_level_q + C_LW'(1);
            else if (!rx_push_ok && rx_pop) rx_level_q <= rx_level_q - C_LW'(1);
        end
    end

    assign rx_valid     = (rx_level_q != '0);
    assign rx_level     = rx_level_q;
    assign rx_data      = rx_valid ? fifo_mem_q[rd_ptr_q] : '1;
    assign rx_frame_err = rx_frame_err_q;
    assign rx_overrun   = rx_overrun_q;
`ifdef UART_PARITY_EN
    assign rx_parity_err = rx_parity_err_q;
`else
    assign rx_parity_err = 1'b0;
`endif

    // ------------------------------------------------------------------ TX --
    tx_state_t            tx_state_q;
    logic [C_CW-1:0]      tx_cnt_q;
    logic [C_BW-1:0]      tx_bit_q;
    logic [C_TX_BITS-1:0] tx_shift_q;
    logic                 ser_tx_q;
    logic                 tx_ready_q;
    logic [C_TX_BITS-1:0] tx_frame;

    // Whole frame, LSB is transmitted first.
`ifdef UART_PARITY_EN
    assign tx_frame = {{STOP_BITS{1'b1}}, (^tx_data) ^ C_ODD, tx_data, 1'b0};
`else
    assign tx_frame = {{STOP_BITS{1'b1}}, tx_data, 1'b0};
`endif

    // Transmitter: guard interval after reset, then one frame per handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_state_q <= TX_GUARD;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '1;
            ser_tx_q   <= 1'b1;
            tx_ready_q <= 1'b0;
        end else begin
            case (tx_state_q)
                TX_GUARD: begin
                    if (tx_cnt_q == C_DIV_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == C_GUARD_LAST) begin
                            tx_bit_q   <= '0;
                            tx_ready_q <= 1'b1;
                            tx_state_q <= TX_IDLE;
                        end else begin
                            tx_bit_q <= tx_bit_q + C_BW'(1);
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + C_CW'(1);
                    end
                end
                TX_IDLE: begin
                    if (tx_valid && tx_ready_q) begin
                        tx_shift_q <= tx_frame;
                        ser_tx_q   <= tx_frame[0];
                        tx_ready_q <= 1'b0;
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_state_q <= TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    if (tx_cnt_q == C_DIV_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == C_TX_LAST) begin
                            ser_tx_q   <= 1'b1;
                            tx_ready_q <= 1'b1;
                            tx_state_q <= TX_IDLE;
                        end else begin
                            tx_bit_q   <= tx_bit_q + C_BW'(1);
                            ser_tx_q   <= tx_shift_q[1];
                            tx_shift_q <= {1'b1, tx_shift_q[C_TX_BITS-1:1]};
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + C_CW'(1);
                    end
                end
                default: begin
                    tx_cnt_q   <= '0;
                    tx_bit_q   <= '0;
                    ser_tx_q   <= 1'b1;
                    tx_ready_q <= 1'b0;
                    tx_state_q <= TX_GUARD;
                end
            endcase
        end
    end

    assign ser_tx   = ser_tx_q;
    assign tx_ready = tx_ready_q;

endmodule
`default_nettype wire
